// File: rtl/fp_mult_pipe_pkg.sv
// Shared types for the pipelined floating-point multiplier: operand class,
// exception flag bundle and the exponent bias helper.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  typedef struct packed {
    logic inf;
    logic nan;
    logic zero;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result bus of fp_mult_pipe. The master drives operands and
// out_ready; the slave (the multiplier) drives in_ready, the result and flags.
interface fp_mult_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  // A transfer happens on a rising edge where valid && ready; valid must not
  // depend on ready, and a raised out_valid holds result/flags until accepted.
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         inf;
  logic         nan;
  logic         zero;
  logic         overflow;
  logic         underflow;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, result, inf, nan, zero, overflow, underflow
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, result, inf, nan, zero, overflow, underflow
  );

endinterface

// File: rtl/fp_mult_pipe_classify.sv
// fp_classify: splits one {sign, exp, man} operand into class, sign, exponent
// and the mantissa with its hidden bit restored. Subnormals decode as zero.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output fp_class_t            cls,
  output logic                 sign,
  output logic [EXP_W-1:0]     exponent,
  output logic [MAN_W:0]       man
);

  logic [MAN_W-1:0] frac;

  always_comb begin
    sign     = op[EXP_W+MAN_W];
    exponent = op[EXP_W+MAN_W-1 -: EXP_W];
    frac     = op[MAN_W-1:0];
    man      = {(exponent != '0), frac};
    if (exponent == '0) begin
      cls = FP_ZERO;
    end else if (&exponent) begin
      cls = (frac == '0) ? FP_INF : FP_NAN;
    end else begin
      cls = FP_NORM;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage floating-point multiplier with valid/ready flow
// control. Define FP_MULT_RNE_EN for round-to-nearest-even; otherwise truncate.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          clk,
  input logic          reset,
  fp_mult_pipe_if.slave bus
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * (MAN_W + 1);

  localparam logic signed [EW-1:0] BIAS_S   = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX_S   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ZERO_S   = '0;
  localparam logic [EXP_W-1:0]     EMAX     = '1;
  localparam logic [MAN_W-1:0]     QNAN_MAN = MAN_W'(1) << (MAN_W - 1);

  // Whole pipe moves together; a held result freezes every stage behind it.
  logic advance;

  // Operand decode
  fp_class_t        cls_x, cls_y;
  logic             sign_x, sign_y;
  logic [EXP_W-1:0] exp_x, exp_y;
  logic [MAN_W:0]   man_x, man_y;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_x (
    .op(bus.x), .cls(cls_x), .sign(sign_x), .exponent(exp_x), .man(man_x)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_y (
    .op(bus.y), .cls(cls_y), .sign(sign_y), .exponent(exp_y), .man(man_y)
  );

  // Stage registers
  logic                    s1_valid;
  fp_class_t               s1_cls_x, s1_cls_y;
  logic                    s1_sign;
  logic signed [EW-1:0]    s1_esum;
  logic [MAN_W:0]          s1_man_x, s1_man_y;

  logic                    s2_valid;
  fp_class_t               s2_cls_x, s2_cls_y;
  logic                    s2_sign;
  logic signed [EW-1:0]    s2_esum;
  logic [PW-1:0]           s2_prod;

  logic                    s3_valid;
  logic [W-1:0]            s3_result;
  fp_flags_t               s3_flags;

  assign advance = !s3_valid || bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_cls_x <= cls_x;
        s1_cls_y <= cls_y;
        s1_sign  <= sign_x ^ sign_y;
        s1_esum  <= $signed({2'b00, exp_x}) + $signed({2'b00, exp_y}) - BIAS_S;
        s1_man_x <= man_x;
        s1_man_y <= man_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_cls_x <= s1_cls_x;
        s2_cls_y <= s1_cls_y;
        s2_sign  <= s1_sign;
        s2_esum  <= s1_esum;
        s2_prod  <= PW'(s1_man_x) * PW'(s1_man_y);
      end
    end
  end

  // Normalise, round, range-check and pick the special-case result
  logic [PW-1:0]        shifted;
  logic signed [EW-1:0] e_norm;
  logic signed [EW-1:0] e_fin;
  logic [MAN_W-1:0]     frac;
  logic [MAN_W-1:0]     man_fin;
  logic                 is_nan, is_inf, is_zero;
  logic [W-1:0]         res_n;
  fp_flags_t            flags_n;
  logic                 unused_bits;
`ifdef FP_MULT_RNE_EN
  logic                 guard, sticky, round_up, carry;
`endif

  always_comb begin
    // Product of two 1.x values lies in [1,4); align the leading one to the top.
    shifted = s2_prod[PW-1] ? s2_prod : {s2_prod[PW-2:0], 1'b0};
    e_norm  = s2_esum + EW'(s2_prod[PW-1]);
    frac    = shifted[PW-2 -: MAN_W];
`ifdef FP_MULT_RNE_EN
    guard    = shifted[PW-2-MAN_W];
    sticky   = |shifted[PW-3-MAN_W:0];
    round_up = guard && (sticky || frac[0]);
    {carry, man_fin} = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    e_fin       = e_norm + EW'(carry);
    unused_bits = shifted[PW-1];
`else
    man_fin     = frac;
    e_fin       = e_norm;
    unused_bits = ^{shifted[PW-1], shifted[PW-2-MAN_W:0]};
`endif

    is_nan  = (s2_cls_x == FP_NAN) || (s2_cls_y == FP_NAN) ||
              ((s2_cls_x == FP_INF) && (s2_cls_y == FP_ZERO)) ||
              ((s2_cls_x == FP_ZERO) && (s2_cls_y == FP_INF));
    is_inf  = (s2_cls_x == FP_INF) || (s2_cls_y == FP_INF);
    is_zero = (s2_cls_x == FP_ZERO) || (s2_cls_y == FP_ZERO);

    res_n   = '0;
    flags_n = '0;
    if (is_nan) begin
      res_n       = {1'b0, EMAX, QNAN_MAN};
      flags_n.nan = 1'b1;
    end else if (is_inf) begin
      res_n       = {s2_sign, EMAX, {MAN_W{1'b0}}};
      flags_n.inf = 1'b1;
    end else if (is_zero) begin
      res_n        = {s2_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      flags_n.zero = 1'b1;
    end else if (e_fin >= EMAX_S) begin
      res_n            = {s2_sign, EMAX, {MAN_W{1'b0}}};
      flags_n.overflow = 1'b1;
    end else if (e_fin <= ZERO_S) begin
      res_n             = {s2_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      flags_n.underflow = 1'b1;
    end else begin
      res_n = {s2_sign, e_fin[EXP_W-1:0], man_fin};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_valid  <= 1'b0;
      s3_result <= '0;
      s3_flags  <= '0;
    end else if (advance) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_result <= res_n;
        s3_flags  <= flags_n;
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = s3_valid;
  assign bus.result    = s3_result;
  assign bus.inf       = s3_flags.inf;
  assign bus.nan       = s3_flags.nan;
  assign bus.zero      = s3_flags.zero;
  assign bus.overflow  = s3_flags.overflow;
  assign bus.underflow = s3_flags.underflow;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe at FP32: special cases, rounding, stall
// behaviour and mid-flight reset, checked with immediate assertions.
module tb_fp_mult_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;

  localparam logic [4:0] FL_NONE = 5'b00000;
  localparam logic [4:0] FL_INF  = 5'b10000;
  localparam logic [4:0] FL_NAN  = 5'b01000;
  localparam logic [4:0] FL_ZERO = 5'b00100;
  localparam logic [4:0] FL_OVF  = 5'b00010;
  localparam logic [4:0] FL_UNF  = 5'b00001;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [W-1:0] exp_q[$];

  fp_mult_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] flags_now();
    return {bus.inf, bus.nan, bus.zero, bus.overflow, bus.underflow};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one pair into an empty pipe and check it emerges on the third edge
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input logic [4:0] exp_fl);
    bus.x         = a;
    bus.y         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check({tag, " valid_e1"}, 32'(bus.out_valid), 32'd0);
    step();
    check({tag, " valid_e2"}, 32'(bus.out_valid), 32'd0);
    step();
    check({tag, " valid_e3"}, 32'(bus.out_valid), 32'd1);
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " flags"}, 32'(flags_now()), 32'(exp_fl));
    step();
  endtask

  logic [W-1:0] sx[5];
  logic [W-1:0] sy[5];
  logic [W-1:0] se[5];
  int idx;
  int got;
  int stalls;
  int seen;

  initial begin
    total = 0;
    bad   = 0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst result", bus.result, 32'h0);
    check("rst flags", 32'(flags_now()), 32'h0);

    run_one("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, FL_NONE);
    run_one("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, FL_NAN);
    run_one("neg_inf", 32'hFF800000, 32'h40000000, 32'hFF800000, FL_INF);
    run_one("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, FL_OVF);
    run_one("underflow", 32'h00800000, 32'h00800000, 32'h00000000, FL_UNF);
    run_one("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, FL_NAN);
    run_one("neg_zero", 32'h80000000, 32'h40000000, 32'h80000000, FL_ZERO);
    run_one("subnorm_flush", 32'h00000001, 32'h3F800000, 32'h00000000, FL_ZERO);
`ifdef FP_MULT_RNE_EN
    run_one("round", 32'h3FC00001, 32'h3FC00001, 32'h40100002, FL_NONE);
`else
    run_one("round", 32'h3FC00001, 32'h3FC00001, 32'h40100001, FL_NONE);
`endif

    // Back-to-back stream with the consumer stalling in cycles 3..6
    sx[0] = 32'h3F800000; sy[0] = 32'h3F800000; se[0] = 32'h3F800000;
    sx[1] = 32'h40000000; sy[1] = 32'h40400000; se[1] = 32'h40C00000;
    sx[2] = 32'h3FC00000; sy[2] = 32'h3FC00000; se[2] = 32'h40100000;
    sx[3] = 32'hC0000000; sy[3] = 32'h3F000000; se[3] = 32'hBF800000;
    sx[4] = 32'h40400000; sy[4] = 32'h40400000; se[4] = 32'h41100000;
    for (int i = 0; i < 5; i++) exp_q.push_back(se[i]);
    idx    = 0;
    got    = 0;
    stalls = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      bus.in_valid  = (idx < 5);
      if (idx < 5) begin
        bus.x = sx[idx];
        bus.y = sy[idx];
      end
      #1;
      if (!bus.in_ready) stalls++;
      if (cyc >= 3 && cyc <= 6) check("stream held", bus.result, se[0]);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream extra", 32'd1, 32'd0);
        end else begin
          check("stream result", bus.result, exp_q.pop_front());
          check("stream flags", 32'(flags_now()), 32'(FL_NONE));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream count", 32'(got), 32'd5);
    check("stream left", 32'(exp_q.size()), 32'd0);
    check("stream stalls", 32'(stalls), 32'd4);

    // Reset with two operations in flight
    bus.x        = 32'h3FC00000;
    bus.y        = 32'h40000000;
    bus.in_valid = 1'b1;
    step();
    bus.x = 32'h40000000;
    bus.y = 32'h40400000;
    step();
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    step();
    reset = 1'b0;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst result", bus.result, 32'h0);
    check("midrst flags", 32'(flags_now()), 32'h0);
    seen = 0;
    repeat (6) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("midrst ghost", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Pipelined, parametrised IEEE-754-style floating-point multiplier with valid/ready handshakes on both sides. It accepts one operand pair per cycle and produces the product and exception flags three cycles later. The block is generalised in exponent and mantissa width, and it supports backpressure and configurable rounding. It is the datapath multiplier for the lab processor's FP execution unit and for standalone FP test harnesses.

## Interface
- EXP_W, default 8: exponent field width.
- MAN_W, default 23: stored mantissa width, excluding the hidden bit.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  the operand pair is valid.
- in_ready  out  1  the block accepts the pair this cycle.
- x, y  in  1+EXP_W+MAN_W each  operands in {sign, exp, man} format.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  the consumer accepts the result.
- result  out  1+EXP_W+MAN_W  product.
- inf, nan, zero, overflow, underflow  out  1 each  exception flags, aligned with result.

## Operation
- Bias is 2^(EXP_W-1)-1. EMAX is the all-ones exponent.
- Operand classes:
  - ZERO: exponent 0. Subnormals are flushed to zero.
  - INF: exponent EMAX, mantissa 0.
  - NAN: exponent EMAX, mantissa nonzero.
  - NORM: everything else.
- Sign of the result is x.sign XOR y.sign, except for NaN results.
- Flag priority: exactly one flag, or none, is set per result. The cases below are checked in order.
  - Either operand is NAN, or the pair is INF times ZERO: result is the canonical NaN {0, EMAX, 1 followed by zeros}; nan=1.
  - Either operand is INF: result is {s, EMAX, 0}; inf=1.
  - Either operand is ZERO: result is {s, 0, 0}; zero=1.
  - Otherwise, compute the normal product as below.
- Normal product:
  - Mantissa: (1.mx) times (1.my) gives a 2(MAN_W+1)-bit product.
  - Exponent: e = ex + ey - bias, computed signed in EXP_W+2 bits.
  - If product bit 2MAN_W+1 is set, shift right by 1 and increment e.
  - Round at the MAN_W-th fraction bit using guard and sticky bits, as selected under Configuration.
  - If rounding carries to 2.0, renormalise: mantissa becomes 0 and e increments.
  - Range check after rounding:
    - e ≥ EMAX: result {s, EMAX, 0}; overflow=1.
    - e ≤ 0: result {s, 0, 0}; underflow=1.
  - Otherwise: result {s, e[EXP_W-1:0], man}; no flags.

## Timing
- Pipeline stages:
  - S1 registers the operand classes, sign and raw exponent sum.
  - S2 registers the full mantissa product.
  - S3 registers the normalised, rounded and packed result plus flags.
- Latency is 3 cycles from the in_valid&&in_ready edge to out_valid. Throughput is 1 per cycle.
- Stall rule:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance=0, every stage holds, including the valid bits and data.
- Bubbles: each stage carries its own valid bit. Bubbles flow through and never assert out_valid.
- Handshake:
  - Once out_valid rises, result and flags stay stable until out_ready.
  - Simultaneous out_ready and a new S2 entry shift the pipe with no gap.
- Reset:
  - Clears all stage valid bits.
  - out_valid=0; result=0; all flags=0.
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation discards in-flight operations with no partial outputs.

## Configuration
- FP_MULT_RNE_EN defined: round to nearest, ties to even. The round-up condition is guard && (sticky || lsb).
- FP_MULT_RNE_EN undefined: truncate toward zero. The guard and sticky logic is not instantiated.
- The rounding carry and renormalise path exists only when the macro is defined.

## Structure
- Package fp_pkg holds:
  - the enum fp_class_t {FP_ZERO, FP_NORM, FP_INF, FP_NAN};
  - the packed struct fp_flags_t {inf, nan, zero, overflow, underflow};
  - the parametrised bias function.
- Sub-module fp_classify decodes one operand into its class, sign, exponent and hidden-bit mantissa. It is instantiated twice, in S1.
- The top module contains the pipeline registers, the multiply, and the normalise, round and range logic.

## Test plan
All cases use the default FP32 parameters.
- 0x3FC00000 × 0x40000000 -> after 3 cycles, 0x40400000 with no flags.
- 0x7F800000 × 0x00000000 -> 0x7FC00000, nan=1. 0xFF800000 × 0x40000000 -> 0xFF800000, inf=1.
- 0x7F000000 × 0x40000000 -> 0x7F800000, overflow=1. 0x00800000 × 0x00800000 -> 0x00000000, underflow=1.
- 0x3FC00001 × 0x3FC00001 -> 0x40100002 with FP_MULT_RNE_EN defined, 0x40100001 without it.
- Stream 5 back-to-back pairs with out_ready held low for cycles 3–6 -> in_ready drops, nothing is lost or duplicated, and results come out in order.
- Assert reset with 2 operations in flight -> out_valid=0 the next cycle, neither result ever appears, and in_ready=1.
